disturb_irq_gen: RTL and testbench

Produces `interrupt_flag` for the light-flow LED sequencer, so a user can freeze the light pattern and later resume it. A mechanical push button is synchronised, debounced and edge-detected. Each confirmed press toggles a registered `interrupt_flag`. A programmable timeout or a software clear drops the flag and resumes the pattern automatically. The block sits between the board key input and the LED sequencer, in the `clk_out` domain.

---
 rtl/disturb_irq_gen_pkg.sv | 22 ++
 rtl/disturb_irq_gen_if.sv | 33 +++
 rtl/disturb_irq_gen_key_debounce.sv | 103 ++++++++++
 rtl/disturb_irq_gen.sv | 85 ++++++++
 tb/tb_disturb_irq_gen.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/disturb_irq_gen_pkg.sv
// -----------------------------------------------------------------------------
// lightflow_pkg
// Shared definitions for the light-flow LED sequencer interrupt logic.
//   db_state_t        : 2-bit debounce FSM state encoding
//   DEBOUNCE_CYC_DEF  : default debounce length in clk_out cycles (20 ms @ 50 kHz)
//   TIMEOUT_CYC_DEF   : default interrupt auto-clear timeout in clk_out cycles
//   CNT_W_DEF         : default counter width, wide enough for both defaults
// -----------------------------------------------------------------------------
package lightflow_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } db_state_t;

    localparam int unsigned DEBOUNCE_CYC_DEF = 1000;
    localparam int unsigned TIMEOUT_CYC_DEF  = 250000;
    localparam int unsigned CNT_W_DEF        = 18;

endpackage

// File: rtl/disturb_irq_gen_if.sv
// -----------------------------------------------------------------------------
// disturb_irq_gen_if
// Bundles the key/interrupt signals between the board key, the software clear
// source and the LED sequencer.
//   key_n          : raw push button, active-low, asynchronous
//   irq_clr        : single-cycle synchronous clear pulse
//   interrupt_flag : level, high freezes the LED pattern
//   key_pulse      : one-cycle strobe per confirmed press
// Modports: master drives key_n/irq_clr, slave (the generator) drives the
// flag and the strobe.
// -----------------------------------------------------------------------------
interface disturb_irq_gen_if;

    logic key_n;
    logic irq_clr;
    logic interrupt_flag;
    logic key_pulse;

    modport master (
        output key_n,
        output irq_clr,
        input  interrupt_flag,
        input  key_pulse
    );

    modport slave (
        input  key_n,
        input  irq_clr,
        output interrupt_flag,
        output key_pulse
    );

endinterface

// File: rtl/disturb_irq_gen_key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Synchronises the raw active-low key, debounces press and release with a
// four-state FSM and reports each confirmed press.
//   clk_out   : system clock
//   rst       : asynchronous active-high reset
//   key_n     : raw push button, active-low, asynchronous to clk_out
//   confirm   : combinational, high in the cycle whose edge completes a press
//   key_pulse : registered copy of confirm, one cycle per confirmed press
// -----------------------------------------------------------------------------
module key_debounce
    import lightflow_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic clk_out,
    input  logic rst,
    input  logic key_n,
    output logic confirm,
    output logic key_pulse
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync_1;
    logic             key_s;
    db_state_t        state;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser; resets to the released level so a key held
    // through reset is seen as a fresh press afterwards.
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b1;
            key_s  <= 1'b1;
        end else begin
            sync_1 <= key_n;
            key_s  <= sync_1;
        end
    end

    // The press is confirmed on the edge that would otherwise move the counter
    // past DEBOUNCE_CYC-1 while the key is still low.
    assign confirm = (state == DB_PRESS) && !key_s && (cnt == DB_LAST);

    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!key_s) begin
                        state <= DB_PRESS;
                        cnt   <= '0;
                    end
                end
                DB_PRESS: begin
                    if (key_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (key_s) begin
                        state <= DB_RELEASE;
                        cnt   <= '0;
                    end
                end
                DB_RELEASE: begin
                    if (!key_s) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            key_pulse <= 1'b0;
        end else begin
            key_pulse <= confirm;
        end
    end

endmodule

// File: rtl/disturb_irq_gen.sv
// -----------------------------------------------------------------------------
// disturb_irq_gen
// Generates the freeze request for the light-flow LED sequencer. Each
// confirmed key press toggles interrupt_flag; a software clear or the
// programmable timeout drops it again.
//   clk_out : system clock shared with the LED sequencer
//   rst     : asynchronous active-high reset
//   bus     : slave side of disturb_irq_gen_if
//             (key_n, irq_clr in; interrupt_flag, key_pulse out)
// Flag priority: irq_clr > press toggle > timeout expiry > hold.
// -----------------------------------------------------------------------------
module disturb_irq_gen
    import lightflow_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int unsigned TIMEOUT_CYC  = TIMEOUT_CYC_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic            clk_out,
    input  logic            rst,
    disturb_irq_gen_if.slave bus
);

    // TIMEOUT_CYC of 0 disables expiry, so its compare value is never used.
    localparam logic [CNT_W-1:0] TO_LAST =
        (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);
    localparam logic TO_EN = (TIMEOUT_CYC != 0);

    logic             confirm;
    logic             key_pulse;
    logic             flag;
    logic             flag_next;
    logic             expire;
    logic [CNT_W-1:0] tcnt;

    key_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .CNT_W        (CNT_W)
    ) u_key_debounce (
        .clk_out   (clk_out),
        .rst       (rst),
        .key_n     (bus.key_n),
        .confirm   (confirm),
        .key_pulse (key_pulse)
    );

    assign expire = TO_EN && flag && (tcnt == TO_LAST);

    // A press coinciding with expiry toggles a set flag to 0, which already
    // agrees with the expiry, so no extra case is needed.
    always_comb begin
        flag_next = flag;
        if (bus.irq_clr) begin
            flag_next = 1'b0;
        end else if (confirm) begin
            flag_next = ~flag;
        end else if (expire) begin
            flag_next = 1'b0;
        end
    end

    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            flag <= 1'b0;
        end else begin
            flag <= flag_next;
        end
    end

    // The counter sits at 0 while the flag is low, so on a rising edge it
    // starts from 0 and expiry lands exactly TIMEOUT_CYC cycles later.
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
        end else if (!TO_EN || !flag || expire) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    assign bus.interrupt_flag = flag;
    assign bus.key_pulse      = key_pulse;

endmodule

// File: tb/tb_disturb_irq_gen.sv
// -----------------------------------------------------------------------------
// tb_disturb_irq_gen
// Drives two generators (timeout 20 and timeout disabled) with identical key
// and clear stimulus. A reference model predicts the outputs for every clock
// edge and queues them; a monitor pops and compares after each edge.
// -----------------------------------------------------------------------------
module tb_disturb_irq_gen;

    localparam int DEB = 4;
    localparam int TO  = 20;

    logic clk_out = 1'b0;
    logic rst     = 1'b1;

    always #5 clk_out = ~clk_out;

    disturb_irq_gen_if ifa ();
    disturb_irq_gen_if ifb ();

    disturb_irq_gen #(.DEBOUNCE_CYC(DEB), .TIMEOUT_CYC(TO), .CNT_W(18)) dut_a (
        .clk_out (clk_out),
        .rst     (rst),
        .bus     (ifa)
    );

    disturb_irq_gen #(.DEBOUNCE_CYC(DEB), .TIMEOUT_CYC(0), .CNT_W(18)) dut_b (
        .clk_out (clk_out),
        .rst     (rst),
        .bus     (ifb)
    );

    typedef struct packed {
        logic fa;
        logic fb;
        logic p;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: key samples seen by the debouncer, whether the
    // key is considered down, length of the current run at the opposite level,
    // edge counter, and per-instance flag with the edge number it rose at.
    bit m_s1, m_s2, m_down, m_pulse, m_fa, m_fb;
    int m_run, m_edge, m_rise_a, m_rise_b;

    function automatic void model_reset();
        m_s1 = 1'b1; m_s2 = 1'b1; m_down = 1'b0; m_pulse = 1'b0;
        m_fa = 1'b0; m_fb = 1'b0; m_run = 0;
    endfunction

    // A level change is accepted once the debouncer has sampled the new level
    // DEB+1 times in a row (one entry sample plus DEB counted cycles).
    function automatic void model_edge(bit k, bit c);
        bit ks, conf, exp_a, na, nb;
        ks = m_s2; m_s2 = m_s1; m_s1 = k;
        conf = 1'b0;
        if (!m_down) begin
            m_run = (ks == 1'b0) ? m_run + 1 : 0;
            if (m_run == DEB + 1) begin m_down = 1'b1; m_run = 0; conf = 1'b1; end
        end else begin
            m_run = (ks == 1'b1) ? m_run + 1 : 0;
            if (m_run == DEB + 1) begin m_down = 1'b0; m_run = 0; end
        end
        m_edge++;
        exp_a = m_fa && (m_edge - m_rise_a == TO);
        if (c) na = 1'b0; else if (conf) na = ~m_fa; else if (exp_a) na = 1'b0; else na = m_fa;
        if (c) nb = 1'b0; else if (conf) nb = ~m_fb; else nb = m_fb;
        if (!m_fa && na) m_rise_a = m_edge;
        if (!m_fb && nb) m_rise_b = m_edge;
        m_fa = na; m_fb = nb; m_pulse = conf;
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.fa = m_fa; e.fb = m_fb; e.p = m_pulse;
        q.push_back(e);
    endfunction

    task automatic check(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
        end
    endtask

    task automatic drive(input bit k, input bit c);
        ifa.key_n = k; ifb.key_n = k; ifa.irq_clr = c; ifb.irq_clr = c;
    endtask

    task automatic step(input bit k, input bit c, input bit r);
        @(negedge clk_out);
        rst = r;
        drive(k, c);
        if (r) model_reset(); else model_edge(k, c);
        push_exp();
    endtask

    // Asserts reset in the middle of a low phase and checks that the outputs
    // drop before any clock edge, then holds it and releases it at a negedge.
    task automatic reset_pulse(input int cycles, input bit k);
        @(negedge clk_out);
        drive(k, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_flag_a",  ifa.interrupt_flag, 1'b0);
        check("async_rst_flag_b",  ifb.interrupt_flag, 1'b0);
        check("async_rst_pulse_a", ifa.key_pulse,      1'b0);
        check("async_rst_pulse_b", ifb.key_pulse,      1'b0);
        model_reset();
        push_exp();
        repeat (cycles - 1) step(k, 1'b0, 1'b1);
        step(k, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_out);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("key_pulse_a", ifa.key_pulse,      e.p);
                check("key_pulse_b", ifb.key_pulse,      e.p);
                check("flag_a",      ifa.interrupt_flag, e.fa);
                check("flag_b",      ifb.interrupt_flag, e.fb);
            end
        end
    end

    initial begin : driver
        bit k;
        int len;
        drive(1'b1, 1'b0);
        model_reset();
        m_edge = 0; m_rise_a = 0; m_rise_b = 0;

        // Power-on reset, then quiet for 50 cycles.
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        repeat (50) step(1'b1, 1'b0, 1'b0);

        // Clean press, release, second press inside the timeout window.
        repeat (8)  step(1'b0, 1'b0, 1'b0);
        repeat (7)  step(1'b1, 1'b0, 1'b0);
        repeat (8)  step(1'b0, 1'b0, 1'b0);
        repeat (10) step(1'b1, 1'b0, 1'b0);

        // Bounce shorter than the debounce window.
        repeat (3)  step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (3)  step(1'b0, 1'b0, 1'b0);
        repeat (10) step(1'b1, 1'b0, 1'b0);

        // Press then idle: timeout on A, disabled timeout keeps B set.
        repeat (8)    step(1'b0, 1'b0, 1'b0);
        repeat (1030) step(1'b1, 1'b0, 1'b0);

        // irq_clr on the confirm cycle.
        repeat (6) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        repeat (8) step(1'b1, 1'b0, 1'b0);

        // Second confirm aligned with A's expiry edge.
        repeat (7)  step(1'b0, 1'b0, 1'b0);
        repeat (13) step(1'b1, 1'b0, 1'b0);
        repeat (7)  step(1'b0, 1'b0, 1'b0);
        repeat (30) step(1'b1, 1'b0, 1'b0);

        // Held key with a reset in the middle.
        repeat (100) step(1'b0, 1'b0, 1'b0);
        reset_pulse(3, 1'b0);
        repeat (100) step(1'b0, 1'b0, 1'b0);
        repeat (10)  step(1'b1, 1'b0, 1'b0);

        // Random key levels, clears and resets.
        for (int i = 0; i < 80; i++) begin
            k   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 12);
            if ($urandom_range(0, 19) == 0) reset_pulse($urandom_range(1, 3), k);
            repeat (len) step(k, ($urandom_range(0, 15) == 0), 1'b0);
        end
        repeat (20) step(1'b1, 1'b0, 1'b0);

        repeat (3) @(posedge clk_out);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
